// File: rtl/display_scan_if.sv
// Bus between the display scan controller and its client: code loading,
// handshake and the scan outputs. blink_mask exists only when SCAN_BLINK_EN
// is defined.
interface display_scan_if #(
    parameter int N_DIGITS = 4
);
    logic [5*N_DIGITS-1:0] code_in;
    logic                  load;
    logic                  ready;
    logic [4:0]            seg_code;
    logic [N_DIGITS-1:0]   digit_en;
    logic                  frame_start;
`ifdef SCAN_BLINK_EN
    logic [N_DIGITS-1:0]   blink_mask;

    modport master (
        output code_in, load, blink_mask,
        input  ready, seg_code, digit_en, frame_start
    );

    modport slave (
        input  code_in, load, blink_mask,
        output ready, seg_code, digit_en, frame_start
    );
`else
    modport master (
        output code_in, load,
        input  ready, seg_code, digit_en, frame_start
    );

    modport slave (
        input  code_in, load,
        output ready, seg_code, digit_en, frame_start
    );
`endif
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed display scan controller: one shared 5-bit code decoder is
// stepped across N_DIGITS one-hot digit enables, with blanking gaps between
// digits. New codes are taken into a shadow register and copied into the
// displayed set only at the frame boundary, so a frame never mixes old and
// new codes. Optional macro SCAN_BLINK_EN adds per-digit blinking.
module display_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYC    = 16
`ifdef SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 32
`endif
) (
    input  logic          clk,
    input  logic          rst,
    display_scan_if.slave bus
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(N_DIGITS);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         w_idx_nxt;
    logic                  w_enter_show;
    logic                  w_frame_end;
    logic                  w_frame_first;
    logic [N_DIGITS-1:0]   w_onehot;
    logic [N_DIGITS-1:0]   w_hide;

    logic [4:0]            r_disp [N_DIGITS];
    logic [5*N_DIGITS-1:0] r_shadow;
    logic                  r_ready;
    logic [4:0]            r_seg_code;
    logic [N_DIGITS-1:0]   r_digit_en;
    logic                  r_frame_start;

    // Scan state, dwell counter and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next scan state: BLANK_CYC dark cycles, then REFRESH_DIV lit cycles per digit
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_idx_nxt    = r_idx;
        w_enter_show = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == CW'(BLANK_CYC - 1)) begin
                    w_state_nxt  = ST_SHOW;
                    w_cnt_nxt    = '0;
                    w_enter_show = 1'b1;
                end
            end
            ST_SHOW: begin
                if (r_cnt == CW'(REFRESH_DIV - 1)) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    if (r_idx == IW'(N_DIGITS - 1)) begin
                        w_idx_nxt   = '0;
                        w_frame_end = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // One-hot enable for the digit about to be lit
    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
    end

    assign w_frame_first = w_enter_show && (r_idx == '0);

`ifdef SCAN_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0]       r_fcnt;
    logic                r_phase;
    logic [N_DIGITS-1:0] r_mask;
    logic [N_DIGITS-1:0] w_mask_now;

    // The mask captured on the frame_start edge already applies to digit 0
    assign w_mask_now = w_frame_first ? bus.blink_mask : r_mask;
    assign w_hide     = r_phase ? w_mask_now : '0;

    // Frame counter: blink phase flips every BLINK_FRAMES frames; mask held per frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt  <= '0;
            r_phase <= 1'b0;
            r_mask  <= '0;
        end else begin
            if (w_frame_first) begin
                r_mask <= bus.blink_mask;
            end
            if (w_frame_end) begin
                if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
        end
    end
`else
    assign w_hide = '0;
`endif

    // Registered scan outputs: code and enable change only on slot edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_code    <= '0;
            r_digit_en    <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_first;
            if (w_enter_show) begin
                r_digit_en <= w_onehot & ~w_hide;
                r_seg_code <= r_disp[r_idx];
            end else if (w_state_nxt == ST_BLANK) begin
                r_digit_en <= '0;
            end
        end
    end

    // Load into shadow while ready; commit to displayed codes at frame wrap.
    // ready low is the pending flag, so a load colliding with commit is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_ready  <= 1'b1;
            for (int unsigned k = 0; k < N_DIGITS; k++) begin
                r_disp[k] <= '0;
            end
        end else begin
            if (w_frame_end && !r_ready) begin
                for (int unsigned k = 0; k < N_DIGITS; k++) begin
                    r_disp[k] <= r_shadow[5*k +: 5];
                end
                r_ready <= 1'b1;
            end else if (bus.load && r_ready) begin
                r_shadow <= bus.code_in;
                r_ready  <= 1'b0;
            end
        end
    end

    assign bus.ready       = r_ready;
    assign bus.seg_code    = r_seg_code;
    assign bus.digit_en    = r_digit_en;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: scoreboard of expected outputs built from a
// slot/frame arithmetic model, plus a table of hand-derived spot vectors and
// a hand-written asynchronous reset sequence.
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int SLOT  = RD + BC;
    localparam int FRAME = N * SLOT;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    display_scan_if #(.N_DIGITS(N)) bus ();

    display_scan_ctrl #(
        .N_DIGITS    (N),
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC)
`ifdef SCAN_BLINK_EN
        ,
        .BLINK_FRAMES(BF)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0] de;
        logic [4:0] seg;
        logic       fs;
        logic       rdy;
    } exp_t;

    typedef struct {
        int          run;
        int          s;
        logic        ld;
        logic [19:0] code;
        logic [3:0]  de;
        logic [4:0]  seg;
        logic        fs;
        logic        rdy;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int          m_s;
    logic [4:0]  m_disp [N];
    logic [19:0] m_shadow;
    logic        m_pend;
    logic        m_rdy;
    logic [4:0]  m_seg;
    logic [3:0]  m_mask = 4'b0010;

    function automatic void add(int run, int s, logic ld, logic [19:0] code,
                                logic [3:0] de, logic [4:0] seg, logic fs, logic rdy);
        vec_t v;
        v.run = run; v.s = s; v.ld = ld; v.code = code;
        v.de = de; v.seg = seg; v.fs = fs; v.rdy = rdy;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int s, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s s=%0d got=%0h exp=%0h", name, s, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s      = 0;
        m_shadow = '0;
        m_pend   = 1'b0;
        m_rdy    = 1'b1;
        m_seg    = '0;
        for (int k = 0; k < N; k++) m_disp[k] = '0;
    endtask

    // expected outputs for sample m_s, derived from position within the frame
    task automatic model_push();
        exp_t e;
        int pos, slot, w;
        pos  = m_s % FRAME;
        slot = pos / SLOT;
        w    = pos % SLOT;
        e.de = (w >= BC) ? 4'(1 << slot) : 4'b0000;
`ifdef SCAN_BLINK_EN
        if ((((m_s / FRAME) / BF) % 2) == 1 && m_mask[slot]) e.de = 4'b0000;
`endif
        if (w == BC) m_seg = m_disp[slot];
        e.seg = m_seg;
        e.fs  = (pos == BC);
        e.rdy = m_rdy;
        sb_q.push_back(e);
    endtask

    task automatic model_edge(input logic ld, input logic [19:0] code);
        logic acc;
        acc = ld && m_rdy;
        if (((m_s + 1) % FRAME) == 0 && m_pend) begin
            for (int k = 0; k < N; k++) m_disp[k] = m_shadow[5*k +: 5];
            m_pend = 1'b0;
            m_rdy  = 1'b1;
        end
        if (acc) begin
            m_shadow = code;
            m_pend   = 1'b1;
            m_rdy    = 1'b0;
        end
        m_s = m_s + 1;
        model_push();
    endtask

    task automatic sample(input int run, input int s, output logic ld, output logic [19:0] code);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_empty s=%0d got=none exp=entry", s);
        end else begin
            e = sb_q.pop_front();
            chk("sb_digit_en",    s, 8'(bus.digit_en),    8'(e.de));
            chk("sb_seg_code",    s, 8'(bus.seg_code),    8'(e.seg));
            chk("sb_frame_start", s, 8'(bus.frame_start), 8'(e.fs));
            chk("sb_ready",       s, 8'(bus.ready),       8'(e.rdy));
        end
        ld   = 1'b0;
        code = '0;
        foreach (tbl[i]) begin
            if (tbl[i].run == run && tbl[i].s == s) begin
                chk("tbl_digit_en",    s, 8'(bus.digit_en),    8'(tbl[i].de));
                chk("tbl_seg_code",    s, 8'(bus.seg_code),    8'(tbl[i].seg));
                chk("tbl_frame_start", s, 8'(bus.frame_start), 8'(tbl[i].fs));
                chk("tbl_ready",       s, 8'(bus.ready),       8'(tbl[i].rdy));
                ld   = tbl[i].ld;
                code = tbl[i].code;
            end
        end
    endtask

    task automatic run_phase(input int run, input int last);
        logic        ld;
        logic [19:0] code;
        for (int s = 0; s <= last; s++) begin
            sample(run, s, ld, code);
            if (s < last) begin
                bus.load    = ld;
                bus.code_in = code;
                model_edge(ld, code);
                @(posedge clk);
                @(negedge clk);
                #1;
            end
        end
        bus.load = 1'b0;
    endtask

    initial begin
        // run 0: power-up, load {3,2,1,0} at 15, ignored load of all-31 at 25
        add(0,  0, 0, 20'h0,     4'b0000, 5'd0, 0, 1);
        add(0,  1, 0, 20'h0,     4'b0000, 5'd0, 0, 1);
        add(0,  2, 0, 20'h0,     4'b0001, 5'd0, 1, 1);
        add(0,  9, 0, 20'h0,     4'b0001, 5'd0, 0, 1);
        add(0, 10, 0, 20'h0,     4'b0000, 5'd0, 0, 1);
        add(0, 12, 0, 20'h0,     4'b0010, 5'd0, 0, 1);
        add(0, 15, 1, 20'h18820, 4'b0010, 5'd0, 0, 1);
        add(0, 16, 0, 20'h0,     4'b0010, 5'd0, 0, 0);
        add(0, 22, 0, 20'h0,     4'b0100, 5'd0, 0, 0);
        add(0, 25, 1, 20'hFFFFF, 4'b0100, 5'd0, 0, 0);
        add(0, 32, 0, 20'h0,     4'b1000, 5'd0, 0, 0);
        add(0, 39, 0, 20'h0,     4'b1000, 5'd0, 0, 0);
        add(0, 40, 0, 20'h0,     4'b0000, 5'd0, 0, 1);
        add(0, 42, 0, 20'h0,     4'b0001, 5'd0, 1, 1);
        add(0, 52, 0, 20'h0,     4'b0010, 5'd1, 0, 1);
        add(0, 62, 0, 20'h0,     4'b0100, 5'd2, 0, 1);
        add(0, 72, 0, 20'h0,     4'b1000, 5'd3, 0, 1);
        add(0, 80, 0, 20'h0,     4'b0000, 5'd3, 0, 1);
        add(0, 82, 0, 20'h0,     4'b0001, 5'd0, 1, 1);
        add(0, 105, 0, 20'h0,    4'b0100, 5'd2, 0, 1);
        // run 1: after mid-SHOW reset; load A at 5, B collides with commit, C at 41
        add(1,  0, 0, 20'h0,     4'b0000, 5'd0, 0, 1);
        add(1,  2, 0, 20'h0,     4'b0001, 5'd0, 1, 1);
        add(1,  5, 1, 20'h214C7, 4'b0001, 5'd0, 0, 1);
        add(1,  6, 0, 20'h0,     4'b0001, 5'd0, 0, 0);
        add(1, 39, 1, 20'hFFFFF, 4'b1000, 5'd0, 0, 0);
        add(1, 40, 0, 20'h0,     4'b0000, 5'd0, 0, 1);
        add(1, 41, 1, 20'h4A96C, 4'b0000, 5'd0, 0, 1);
        add(1, 42, 0, 20'h0,     4'b0001, 5'd7, 1, 0);
        add(1, 52, 0, 20'h0,     4'b0010, 5'd6, 0, 0);
        add(1, 72, 0, 20'h0,     4'b1000, 5'd4, 0, 0);
        add(1, 80, 0, 20'h0,     4'b0000, 5'd4, 0, 1);
        add(1, 82, 0, 20'h0,     4'b0001, 5'd12, 1, 1);
`ifdef SCAN_BLINK_EN
        add(1, 92, 0, 20'h0,     4'b0000, 5'd11, 0, 1);
        add(1, 172, 0, 20'h0,    4'b0010, 5'd11, 0, 1);
`else
        add(1, 92, 0, 20'h0,     4'b0010, 5'd11, 0, 1);
`endif

        bus.load    = 1'b0;
        bus.code_in = '0;
`ifdef SCAN_BLINK_EN
        bus.blink_mask = m_mask;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        model_push();
        #1;
        run_phase(0, 105);

        // asynchronous reset in the middle of digit 2's lit slot
        rst = 1'b1;
        #1;
        chk("rst_digit_en",    105, 8'(bus.digit_en),    8'h00);
        chk("rst_seg_code",    105, 8'(bus.seg_code),    8'h00);
        chk("rst_frame_start", 105, 8'(bus.frame_start), 8'h00);
        chk("rst_ready",       105, 8'(bus.ready),       8'h01);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        model_reset();
        model_push();
        #1;
        run_phase(1, 215);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
